block_unperm_stream: RTL and testbench

BLOCK_UNPERM_STREAM -- requirements
Module: block_unperm_stream

---
 rtl/csa_pkg.sv | 28 ++
 rtl/block_perm_inv.sv | 27 ++
 rtl/block_unperm_stream.sv | 142 ++++++++++++++
 tb/tb_block_unperm_stream.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the CSA block byte permutation stream.
// Provides the default block size, the per-direction bit-source tables
// (entry i names the input bit that lands on output bit i) and the
// payload type held in the output FIFO.
package csa_pkg;

    localparam int unsigned BLOCK_BYTES_DEF = 8;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BIT_IDX_W       = 3;

    typedef logic [BYTE_W-1:0][BIT_IDX_W-1:0] bit_map_t;

    // Inverse permutation: out[i] = in[INV_SRC[i]]
    localparam bit_map_t INV_SRC = {
        3'd3, 3'd0, 3'd6, 3'd2, 3'd4, 3'd5, 3'd7, 3'd1
    };

    // Forward permutation: out[i] = in[FWD_SRC[i]]
    localparam bit_map_t FWD_SRC = {
        3'd1, 3'd5, 3'd2, 3'd3, 3'd7, 3'd4, 3'd0, 3'd6
    };

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } fifo_entry_t;

endpackage : csa_pkg

// File: rtl/block_perm_inv.sv
// Combinational byte bit-permutation.
// Ports: din (8b in), dout (8b out), dir_fwd (only with
// BLOCK_UNPERM_DIR_SEL_EN: 1 selects the forward table, 0 the inverse).
// Without BLOCK_UNPERM_DIR_SEL_EN the inverse table is always applied.
module block_perm_inv
    import csa_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
`ifdef BLOCK_UNPERM_DIR_SEL_EN
    input  logic              dir_fwd,
`endif
    output logic [BYTE_W-1:0] dout
);

    // Table-driven bit gather
    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
`ifdef BLOCK_UNPERM_DIR_SEL_EN
            dout[i] = dir_fwd ? din[FWD_SRC[i]] : din[INV_SRC[i]];
`else
            dout[i] = din[INV_SRC[i]];
`endif
        end
    end

endmodule : block_perm_inv

// File: rtl/block_unperm_stream.sv
// Byte stream inverse-permutation with block alignment tracking.
// Each accepted byte is bit-permuted, tagged with an end-of-block flag
// from a running byte index, and queued in a 2-entry output FIFO.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_data/in_sob input handshake, byte, start-of-block
//   out_valid/out_ready/out_data/out_last output handshake, byte, end-of-block
//   err_sync                         sticky misaligned start-of-block flag
//   dir_fwd                          direction select, only with
//                                    BLOCK_UNPERM_DIR_SEL_EN defined
module block_unperm_stream
    import csa_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_sob,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
`ifdef BLOCK_UNPERM_DIR_SEL_EN
    input  logic              dir_fwd,
`endif
    output logic              err_sync
);

    localparam int unsigned IDX_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    logic [BYTE_W-1:0] perm_out;

    // head holds the byte on the output, tail the one queued behind it
    fifo_entry_t      head_q, head_d;
    fifo_entry_t      tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] eff_idx;
    fifo_entry_t      new_e;

    block_perm_inv u_perm (
        .din     (in_data),
`ifdef BLOCK_UNPERM_DIR_SEL_EN
        .dir_fwd (dir_fwd),
`endif
        .dout    (perm_out)
    );

    // Next-state: alignment tracking and FIFO update
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;

        accept      = in_valid & in_ready_q;
        pop         = out_valid_q & out_ready;

        // A start-of-block marker realigns this byte to index 0
        eff_idx     = in_sob ? '0 : idx_q;
        new_e.data  = perm_out;
        new_e.last  = (eff_idx == LAST_IDX);

        if (accept) begin
            idx_d = new_e.last ? '0 : eff_idx + IDX_W'(1);
            if (in_sob && (idx_q != '0)) begin
                err_d = 1'b1;
            end
        end

        case (cnt_q)
            2'd0: begin
                if (accept) begin
                    head_d = new_e;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    head_d = new_e;
                end else if (accept) begin
                    tail_d = new_e;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                // Full: in_ready is low so only a pop can occur
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
            default: begin
                cnt_d = 2'd0;
            end
        endcase

        out_valid_d = (cnt_d != 2'd0);
        in_ready_d  = (cnt_d != 2'd2);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q.data;
    assign out_last  = head_q.last;
    assign err_sync  = err_q;

endmodule : block_unperm_stream

// File: tb/tb_block_unperm_stream.sv
// Self-checking bench for block_unperm_stream. A queue-based reference
// tracks the expected output stream, handshake state and error flag.
module tb_block_unperm_stream;

    localparam int BB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sob;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       err_sync;
`ifdef BLOCK_UNPERM_DIR_SEL_EN
    logic       dir_fwd;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [8:0] mq[$];
    int         m_idx;
    bit         m_err;
    bit         m_rdy_en;

    always #5 clk = ~clk;

    block_unperm_stream #(.BLOCK_BYTES(BB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sob    (in_sob),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
`ifdef BLOCK_UNPERM_DIR_SEL_EN
        .dir_fwd   (dir_fwd),
`endif
        .err_sync  (err_sync)
    );

    // Forward mapping: input bit k moves to position dst[k]
    function automatic logic [7:0] perm_ref(input logic [7:0] b, input bit fwd);
        int dst[8] = '{1, 7, 5, 4, 2, 6, 0, 3};
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (fwd) r[dst[k]] = b[k];
            else     r[k]      = b[dst[k]];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance the model, then one clock
    task automatic step();
        bit         ev, er, acc, pop, fwd;
        int         eff;
        logic [7:0] d;
        ev = (mq.size() > 0);
        er = m_rdy_en && (mq.size() < 2);
        chk("in_ready",  32'(in_ready),  32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("err_sync",  32'(err_sync),  32'(m_err));
        if (ev) begin
            chk("out_data", 32'(out_data), 32'(mq[0][7:0]));
            chk("out_last", 32'(out_last), 32'(mq[0][8]));
        end
        acc = in_valid && er;
        pop = ev && out_ready;
`ifdef BLOCK_UNPERM_DIR_SEL_EN
        fwd = dir_fwd;
`else
        fwd = 1'b0;
`endif
        if (pop) void'(mq.pop_front());
        if (acc) begin
            if (in_sob && m_idx != 0) m_err = 1'b1;
            eff = in_sob ? 0 : m_idx;
            d = perm_ref(in_data, fwd);
            mq.push_back({(eff == BB - 1), d});
            m_idx = (eff + 1) % BB;
        end
        @(posedge clk);
        #1;
        m_rdy_en = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data",  32'(out_data),  32'(0));
        chk("rst_out_last",  32'(out_last),  32'(0));
        chk("rst_err_sync",  32'(err_sync),  32'(0));
        chk("rst_in_ready",  32'(in_ready),  32'(0));
        mq.delete();
        m_idx    = 0;
        m_err    = 1'b0;
        m_rdy_en = 1'b0;
        rst_n    = 1'b1;
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic sob);
        in_valid = 1'b1;
        in_data  = b;
        in_sob   = sob;
        step();
        in_valid = 1'b0;
        in_sob   = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        logic [7:0] vin[5];
        logic [7:0] vexp[5];
        logic [7:0] a;
        vin  = '{8'h02, 8'h80, 8'hB2, 8'hFF, 8'h00};
        vexp = '{8'h01, 8'h02, 8'h0F, 8'hFF, 8'h00};
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sob    = 1'b0;
        out_ready = 1'b1;
`ifdef BLOCK_UNPERM_DIR_SEL_EN
        dir_fwd   = 1'b0;
`endif
        #2;
        do_reset();
        step();
        step();

        // Directed vectors, each visible one cycle after acceptance
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            step();
            chk("vec", 32'(out_data), 32'(vexp[i]));
        end
        drain();

        // Two back-to-back blocks at full rate
        do_reset();
        step();
        for (int i = 0; i < 16; i++) send(8'($urandom), (i == 0));
        drain();
        chk("b2b_err", 32'(err_sync), 32'(0));

        // Backpressure: third byte must wait for space
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        chk("bp_full", 32'(in_ready), 32'(0));
        drain();

        // Misaligned start-of-block on the fourth byte
        do_reset();
        step();
        for (int i = 0; i < 12; i++) send(8'($urandom), (i == 0) || (i == 3));
        drain();
        chk("sob_err_sticky", 32'(err_sync), 32'(1));

        // Reset with a partial block and two bytes buffered
        do_reset();
        step();
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) send(8'($urandom), 1'b0);
        do_reset();
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_sob    = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef BLOCK_UNPERM_DIR_SEL_EN
            dir_fwd   = 1'($urandom_range(0, 1));
`endif
            step();
        end
        in_sob = 1'b0;
        drain();

`ifdef BLOCK_UNPERM_DIR_SEL_EN
        // Forward direction and full round-trip
        do_reset();
        step();
        dir_fwd = 1'b1;
        send(8'h0F, 1'b0);
        chk("fwd_0f", 32'(out_data), 32'(8'hB2));
        for (int v = 0; v < 256; v++) begin
            dir_fwd = 1'b1;
            send(8'(v), 1'b0);
            a = out_data;
            dir_fwd = 1'b0;
            send(a, 1'b0);
            chk("round_trip", 32'(out_data), 32'(v));
        end
        dir_fwd = 1'b0;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_block_unperm_stream
